top_level_multiplier: RTL and testbench



---
 rtl/wallace_pkg.sv | 5 +
 rtl/full_adder.sv | 12 +
 rtl/top_level_multiplier.sv | 120 ++++++++++++
 tb/tb_top_level_multiplier.sv | 90 +++++++++
 4 files changed

// File: rtl/wallace_pkg.sv
// Shared widths for the Wallace6x6 multiplier block.
package wallace_pkg;
  localparam int MULT_W = 6;
  localparam int PROD_W = 2 * MULT_W;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder; used as the 3:2 cell, the half adder (cin tied low)
// and the ripple-carry cell of the final adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/top_level_multiplier.sv
// Unsigned 6x6 Wallace-tree multiplier: AND array, three carry-save stages
// (rows 6 -> 4 -> 3 -> 2), ripple-carry final adder, one output register.
module top_level_multiplier
  import wallace_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [MULT_W-1:0] A,
  input  logic [MULT_W-1:0] B,
  output logic [PROD_W-1:0] P,
  output logic              valid_out
);

  logic [PROD_W-1:0] pp [MULT_W];

  genvar gi, gk;
  generate
    for (gi = 0; gi < MULT_W; gi++) begin : g_pp
      assign pp[gi] = B[gi] ? ({{MULT_W{1'b0}}, A} << gi) : '0;
    end
  endgenerate

  // Each row is a full-width vector; constant-zero bits collapse the 3:2
  // cells into half adders or plain wires where a column is short. Bit 11
  // never produces a carry (product < 4096), so it is a sum-only cell.

  // Stage 1: rows {0,1,2} and {3,4,5} -> four rows.
  logic [PROD_W-1:0] s1_s [2];
  logic [PROD_W-1:0] s1_c [2];
  generate
    for (gi = 0; gi < 2; gi++) begin : g_st1
      logic [PROD_W-2:0] co;
      for (gk = 0; gk < PROD_W - 1; gk++) begin : g_bit
        full_adder u_fa (
          .a   (pp[3*gi][gk]),
          .b   (pp[3*gi+1][gk]),
          .cin (pp[3*gi+2][gk]),
          .sum (s1_s[gi][gk]),
          .cout(co[gk])
        );
      end
      assign s1_s[gi][PROD_W-1] = pp[3*gi][PROD_W-1] ^ pp[3*gi+1][PROD_W-1]
                                  ^ pp[3*gi+2][PROD_W-1];
      assign s1_c[gi] = {co, 1'b0};
    end
  endgenerate

  // Stage 2: three rows compressed, the fourth (s1_c[1]) passes through.
  logic [PROD_W-1:0] s2_s, s2_c;
  logic [PROD_W-2:0] s2_co;
  generate
    for (gk = 0; gk < PROD_W - 1; gk++) begin : g_st2
      full_adder u_fa (
        .a   (s1_s[0][gk]),
        .b   (s1_c[0][gk]),
        .cin (s1_s[1][gk]),
        .sum (s2_s[gk]),
        .cout(s2_co[gk])
      );
    end
  endgenerate
  assign s2_s[PROD_W-1] = s1_s[0][PROD_W-1] ^ s1_c[0][PROD_W-1] ^ s1_s[1][PROD_W-1];
  assign s2_c = {s2_co, 1'b0};

  // Stage 3: three rows -> two.
  logic [PROD_W-1:0] s3_s, s3_c;
  logic [PROD_W-2:0] s3_co;
  generate
    for (gk = 0; gk < PROD_W - 1; gk++) begin : g_st3
      full_adder u_fa (
        .a   (s2_s[gk]),
        .b   (s2_c[gk]),
        .cin (s1_c[1][gk]),
        .sum (s3_s[gk]),
        .cout(s3_co[gk])
      );
    end
  endgenerate
  assign s3_s[PROD_W-1] = s2_s[PROD_W-1] ^ s2_c[PROD_W-1] ^ s1_c[1][PROD_W-1];
  assign s3_c = {s3_co, 1'b0};

  // Final ripple-carry adder; per-bit carries live in the generate scope.
  logic [PROD_W-1:0] prod_d;
  generate
    for (gk = 0; gk < PROD_W - 1; gk++) begin : g_rca
      logic ci, co;
      if (gk == 0) begin : g_c0
        assign ci = 1'b0;
      end else begin : g_cn
        assign ci = g_rca[gk-1].co;
      end
      full_adder u_fa (
        .a   (s3_s[gk]),
        .b   (s3_c[gk]),
        .cin (ci),
        .sum (prod_d[gk]),
        .cout(co)
      );
    end
  endgenerate
  assign prod_d[PROD_W-1] = s3_s[PROD_W-1] ^ s3_c[PROD_W-1] ^ g_rca[PROD_W-2].co;

  logic [PROD_W-1:0] prod_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) prod_q <= prod_d;
    end
  end

  assign P         = prod_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_top_level_multiplier.sv
// Directed and exhaustive checks of the registered 6x6 multiplier.
module tb_top_level_multiplier;
  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [5:0]  A;
  logic [5:0]  B;
  logic [11:0] P;
  logic        valid_out;

  int checks = 0;
  int errors = 0;

  top_level_multiplier dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_in (valid_in),
    .A        (A),
    .B        (B),
    .P        (P),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic rn, input logic v, input logic [5:0] a, input logic [5:0] b);
    rst_n    = rn;
    valid_in = v;
    A        = a;
    B        = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] exp_p, input logic exp_v);
    checks++;
    assert (P === exp_p && valid_out === exp_v)
    else begin
      errors++;
      $error("FAIL %s: P=%0d valid_out=%b, expected P=%0d valid_out=%b",
             tag, P, valid_out, exp_p, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; A = '0; B = '0;

    // Reset held with valid operands present
    drive(1'b0, 1'b1, 6'd63, 6'd63); check("reset_c1", 12'd0, 1'b0);
    drive(1'b0, 1'b1, 6'd63, 6'd63); check("reset_c2", 12'd0, 1'b0);
    drive(1'b1, 1'b1, 6'd63, 6'd63); check("post_reset_63x63", 12'd3969, 1'b1);

    // Directed back-to-back products
    drive(1'b1, 1'b1, 6'd44, 6'd44); check("44x44", 12'd1936, 1'b1);
    drive(1'b1, 1'b1, 6'd21, 6'd63); check("21x63", 12'd1323, 1'b1);
    drive(1'b1, 1'b1, 6'd47, 6'd5);  check("47x5",  12'd235,  1'b1);
    drive(1'b1, 1'b1, 6'd22, 6'd46); check("22x46", 12'd1012, 1'b1);
    drive(1'b1, 1'b1, 6'd0,  6'd45); check("0x45",  12'd0,    1'b1);

    // Extremes
    drive(1'b1, 1'b1, 6'd63, 6'd63); check("63x63", 12'd3969, 1'b1);
    drive(1'b1, 1'b1, 6'd1,  6'd63); check("1x63",  12'd63,   1'b1);
    drive(1'b1, 1'b1, 6'd63, 6'd1);  check("63x1",  12'd63,   1'b1);
    drive(1'b1, 1'b1, 6'd32, 6'd32); check("32x32", 12'd1024, 1'b1);

    // Hold when valid_in drops
    drive(1'b1, 1'b1, 6'd10, 6'd12); check("10x12",  12'd120, 1'b1);
    drive(1'b1, 1'b0, 6'd7,  6'd7);  check("hold_1", 12'd120, 1'b0);
    drive(1'b1, 1'b0, 6'd7,  6'd7);  check("hold_2", 12'd120, 1'b0);

    // Reset mid-stream wins over valid_in
    drive(1'b1, 1'b1, 6'd33, 6'd3);  check("33x3",      12'd99,   1'b1);
    drive(1'b0, 1'b1, 6'd50, 6'd50); check("mid_reset", 12'd0,    1'b0);
    drive(1'b1, 1'b1, 6'd50, 6'd50); check("50x50",     12'd2500, 1'b1);

    // Exhaustive back-to-back sweep
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        drive(1'b1, 1'b1, 6'(a), 6'(b));
        check($sformatf("exh_%0dx%0d", a, b), 12'(a * b), 1'b1);
      end
    end

    drive(1'b1, 1'b0, 6'd1, 6'd1); check("final_hold", 12'd3969, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
